// File: rtl/param_reservation_queue.sv
// param_reservation_queue: age-ordered collapsing reservation station with CDB wakeup and in-order-preferring issue.
// Optional feature macro RSQ_DISPATCH_CDB_BYPASS_EN: a dispatching operand may capture the same-cycle CDB broadcast.
module param_reservation_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OPC_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [DATA_W-1:0]      disp_op1_data,
  input  logic [DATA_W-1:0]      disp_op2_data,
  input  logic [TAG_W-1:0]       disp_op1_tag,
  input  logic [TAG_W-1:0]       disp_op2_tag,
  input  logic                   disp_op1_rdy,
  input  logic                   disp_op2_rdy,
  input  logic [TAG_W-1:0]       disp_rd_tag,
  input  logic [OPC_W-1:0]       disp_opc,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [DATA_W-1:0]      cdb_data,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [DATA_W-1:0]      issue_op1,
  output logic [DATA_W-1:0]      issue_op2,
  output logic [TAG_W-1:0]       issue_rd_tag,
  output logic [OPC_W-1:0]       issue_opc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] ONE_C  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              op1_rdy;
    logic              op2_rdy;
    logic [DATA_W-1:0] op1_data;
    logic [DATA_W-1:0] op2_data;
    logic [TAG_W-1:0]  op1_tag;
    logic [TAG_W-1:0]  op2_tag;
    logic [TAG_W-1:0]  rd_tag;
    logic [OPC_W-1:0]  opc;
  } entry_t;

  entry_t            slot_r     [DEPTH];
  entry_t            slot_ext_s [DEPTH+1];
  entry_t            slot_nxt_s [DEPTH];
  entry_t            disp_entry_s;
  logic [CNT_W-1:0]  occ_r;
  logic [CNT_W-1:0]  occ_nxt_s;
  logic [CNT_W-1:0]  wr_idx_s;
  logic              disp_ready_r;
  logic              sel_found_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic              issue_fire_s;
  logic              disp_fire_s;

  function automatic entry_t cdb_capture(input entry_t e, input logic v,
                                         input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    entry_t r;
    r = e;
    if (e.valid && v && !e.op1_rdy && (e.op1_tag == t)) begin
      r.op1_rdy  = 1'b1;
      r.op1_data = d;
    end else begin
      r.op1_rdy  = e.op1_rdy;
    end
    if (e.valid && v && !e.op2_rdy && (e.op2_tag == t)) begin
      r.op2_rdy  = 1'b1;
      r.op2_data = d;
    end else begin
      r.op2_rdy  = e.op2_rdy;
    end
    return r;
  endfunction

  assign disp_ready = disp_ready_r;
  assign occupancy  = occ_r;

  // Oldest eligible entry; registered ready bits keep CDB wakeup from issuing in the capture cycle
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found_s && slot_r[i].valid && slot_r[i].op1_rdy && slot_r[i].op2_rdy) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Issue port: selected entry, zeroed when nothing is eligible
  always_comb begin
    issue_valid = sel_found_s;
    if (sel_found_s) begin
      issue_op1    = slot_r[sel_idx_s].op1_data;
      issue_op2    = slot_r[sel_idx_s].op2_data;
      issue_rd_tag = slot_r[sel_idx_s].rd_tag;
      issue_opc    = slot_r[sel_idx_s].opc;
    end else begin
      issue_op1    = '0;
      issue_op2    = '0;
      issue_rd_tag = '0;
      issue_opc    = '0;
    end
  end

  // Slot view padded with an empty entry above the top so the collapse shift has a source
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_ext_s[i] = slot_r[i];
    end
    slot_ext_s[DEPTH] = '0;
  end

  // Entry built from the dispatch port
  always_comb begin
    disp_entry_s          = '0;
    disp_entry_s.valid    = 1'b1;
    disp_entry_s.op1_rdy  = disp_op1_rdy;
    disp_entry_s.op2_rdy  = disp_op2_rdy;
    disp_entry_s.op1_data = disp_op1_data;
    disp_entry_s.op2_data = disp_op2_data;
    disp_entry_s.op1_tag  = disp_op1_tag;
    disp_entry_s.op2_tag  = disp_op2_tag;
    disp_entry_s.rd_tag   = disp_rd_tag;
    disp_entry_s.opc      = disp_opc;
`ifdef RSQ_DISPATCH_CDB_BYPASS_EN
    disp_entry_s = cdb_capture(disp_entry_s, cdb_valid, cdb_tag, cdb_data);
`else
    disp_entry_s.valid = 1'b1;
`endif
  end

  // Next state: flush, then dispatch write, then collapse shift plus CDB capture
  always_comb begin
    issue_fire_s = sel_found_s && issue_ready;
    disp_fire_s  = disp_valid && disp_ready_r;
    if (issue_fire_s) begin
      wr_idx_s = occ_r - ONE_C;
    end else begin
      wr_idx_s = occ_r;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        slot_nxt_s[i] = '0;
      end else if (disp_fire_s && (wr_idx_s == CNT_W'(i))) begin
        slot_nxt_s[i] = disp_entry_s;
      end else if (issue_fire_s && (IDX_W'(i) >= sel_idx_s)) begin
        slot_nxt_s[i] = cdb_capture(slot_ext_s[i+1], cdb_valid, cdb_tag, cdb_data);
      end else begin
        slot_nxt_s[i] = cdb_capture(slot_r[i], cdb_valid, cdb_tag, cdb_data);
      end
    end
    if (flush) begin
      occ_nxt_s = '0;
    end else if (disp_fire_s && !issue_fire_s) begin
      occ_nxt_s = occ_r + ONE_C;
    end else if (issue_fire_s && !disp_fire_s) begin
      occ_nxt_s = occ_r - ONE_C;
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // State registers; disp_ready is registered from the next occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_r[i] <= '0;
      end
      occ_r        <= '0;
      disp_ready_r <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_r[i] <= slot_nxt_s[i];
      end
      occ_r        <= occ_nxt_s;
      disp_ready_r <= (occ_nxt_s < FULL_C);
    end
  end

endmodule
